reservation_station: RTL and testbench

Holds decoded ALU-class instructions (R_TYPE, I_TYPE, B_TYPE, AUIPC, JALR) between issue and execution. Entries wait for source operands, snoop the ALU and LSB result buses for their producers' RoB ids, and dispatch one ready entry per cycle to the ALU. Sits directly downstream of the RoB tag allocation in the issue path and upstream of the ALU. All writes to an entry stay inside the slot index of this block; RoB ids travel as opaque tags.

---
 rtl/reservation_station.sv | 200 ++++++++++++++++++++
 tb/tb_reservation_station.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// reservation_station
//   ALU-class issue buffer: operand wakeup from ALU/LSB result buses and
//   lowest-index dispatch, one per cycle. Optional macro: RS_BYPASS_EN.
//   Revision: 1.0
// ============================================================================
module reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             iss_valid,
  input  logic [6:0]       iss_type,
  input  logic [3:0]       iss_funct,
  input  logic [31:0]      iss_vj,
  input  logic [31:0]      iss_vk,
  input  logic [ROB_W-1:0] iss_qj,
  input  logic [ROB_W-1:0] iss_qk,
  input  logic             iss_rj,
  input  logic             iss_rk,
  input  logic [ROB_W-1:0] iss_rob_id,
  input  logic [31:0]      iss_imm,
  input  logic [31:0]      iss_pc,
  input  logic             alu_ready,
  input  logic [ROB_W-1:0] alu_rob_id,
  input  logic [31:0]      alu_value,
  input  logic             lsb_ready,
  input  logic [ROB_W-1:0] lsb_rob_id,
  input  logic [31:0]      lsb_value,
  output logic             rs_full,
  output logic             ex_valid,
  output logic [6:0]       ex_type,
  output logic [3:0]       ex_funct,
  output logic [31:0]      ex_a,
  output logic [31:0]      ex_b,
  output logic [31:0]      ex_imm,
  output logic [31:0]      ex_pc,
  output logic [ROB_W-1:0] ex_rob_id
);

  localparam int C_SLOT_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] rj_q, rk_q;
  logic [RS_SIZE-1:0] ready_vec;
  logic [6:0]         type_q  [RS_SIZE];
  logic [3:0]         funct_q [RS_SIZE];
  logic [31:0]        vj_q    [RS_SIZE];
  logic [31:0]        vk_q    [RS_SIZE];
  logic [ROB_W-1:0]   qj_q    [RS_SIZE];
  logic [ROB_W-1:0]   qk_q    [RS_SIZE];
  logic [31:0]        imm_q   [RS_SIZE];
  logic [31:0]        pc_q    [RS_SIZE];
  logic [ROB_W-1:0]   rob_q   [RS_SIZE];

  logic                ex_valid_q;
  logic [6:0]          ex_type_q;
  logic [3:0]          ex_funct_q;
  logic [31:0]         ex_a_q, ex_b_q, ex_imm_q, ex_pc_q;
  logic [ROB_W-1:0]    ex_rob_q;

  logic [C_SLOT_W-1:0] iss_slot_d, disp_slot_d;
  logic                do_issue_d, any_ready_d;
  logic [31:0]         new_vj_d, new_vk_d;
  logic                new_rj_d, new_rk_d;

  assign ready_vec   = busy_q & rj_q & rk_q;
  assign any_ready_d = |ready_vec;
  // Occupancy after the last edge only; a slot freed this cycle is not offered.
  assign rs_full     = &busy_q;
  assign do_issue_d  = iss_valid & ~rs_full;

  always_comb begin
    iss_slot_d  = '0;
    disp_slot_d = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i])   iss_slot_d  = C_SLOT_W'(i);
      if (ready_vec[i]) disp_slot_d = C_SLOT_W'(i);
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (do_issue_d)  busy_d[iss_slot_d]  = 1'b1;
    if (any_ready_d) busy_d[disp_slot_d] = 1'b0;
  end

  always_comb begin
    new_vj_d = iss_vj;
    new_rj_d = iss_rj;
    new_vk_d = iss_vk;
    new_rk_d = iss_rk;
`ifdef RS_BYPASS_EN
    // Catch a result broadcast in the issue cycle; ALU bus has priority.
    if (!iss_rj) begin
      if (alu_ready && alu_rob_id == iss_qj) begin
        new_vj_d = alu_value;
        new_rj_d = 1'b1;
      end else if (lsb_ready && lsb_rob_id == iss_qj) begin
        new_vj_d = lsb_value;
        new_rj_d = 1'b1;
      end
    end
    if (!iss_rk) begin
      if (alu_ready && alu_rob_id == iss_qk) begin
        new_vk_d = alu_value;
        new_rk_d = 1'b1;
      end else if (lsb_ready && lsb_rob_id == iss_qk) begin
        new_vk_d = lsb_value;
        new_rk_d = 1'b1;
      end
    end
`endif
  end

  // Entry payload carries no reset; busy_q alone qualifies every field.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && !rj_q[i]) begin
          if (alu_ready && alu_rob_id == qj_q[i]) begin
            vj_q[i] <= alu_value;
            rj_q[i] <= 1'b1;
          end else if (lsb_ready && lsb_rob_id == qj_q[i]) begin
            vj_q[i] <= lsb_value;
            rj_q[i] <= 1'b1;
          end
        end
        if (busy_q[i] && !rk_q[i]) begin
          if (alu_ready && alu_rob_id == qk_q[i]) begin
            vk_q[i] <= alu_value;
            rk_q[i] <= 1'b1;
          end else if (lsb_ready && lsb_rob_id == qk_q[i]) begin
            vk_q[i] <= lsb_value;
            rk_q[i] <= 1'b1;
          end
        end
      end
      if (do_issue_d) begin
        type_q[iss_slot_d]  <= iss_type;
        funct_q[iss_slot_d] <= iss_funct;
        vj_q[iss_slot_d]    <= new_vj_d;
        vk_q[iss_slot_d]    <= new_vk_d;
        qj_q[iss_slot_d]    <= iss_qj;
        qk_q[iss_slot_d]    <= iss_qk;
        rj_q[iss_slot_d]    <= new_rj_d;
        rk_q[iss_slot_d]    <= new_rk_d;
        imm_q[iss_slot_d]   <= iss_imm;
        pc_q[iss_slot_d]    <= iss_pc;
        rob_q[iss_slot_d]   <= iss_rob_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_type_q  <= '0;
      ex_funct_q <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      ex_pc_q    <= '0;
      ex_rob_q   <= '0;
    end else if (rdy) begin
      if (clear) begin
        busy_q     <= '0;
        ex_valid_q <= 1'b0;
      end else begin
        busy_q     <= busy_d;
        ex_valid_q <= any_ready_d;
        if (any_ready_d) begin
          ex_type_q  <= type_q[disp_slot_d];
          ex_funct_q <= funct_q[disp_slot_d];
          ex_a_q     <= vj_q[disp_slot_d];
          ex_b_q     <= vk_q[disp_slot_d];
          ex_imm_q   <= imm_q[disp_slot_d];
          ex_pc_q    <= pc_q[disp_slot_d];
          ex_rob_q   <= rob_q[disp_slot_d];
        end
      end
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_type   = ex_type_q;
  assign ex_funct  = ex_funct_q;
  assign ex_a      = ex_a_q;
  assign ex_b      = ex_b_q;
  assign ex_imm    = ex_imm_q;
  assign ex_pc     = ex_pc_q;
  assign ex_rob_id = ex_rob_q;

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// tb_reservation_station
//   Directed scoreboard bench for reservation_station.
//   Revision: 1.0
// ============================================================================
module tb_reservation_station;

  localparam logic [6:0] C_R_TYPE = 7'b0110011;
  localparam logic [6:0] C_I_TYPE = 7'b0010011;
  localparam logic [6:0] C_B_TYPE = 7'b1100011;
  localparam logic [6:0] C_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_JALR   = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, iss_valid;
  logic [6:0]  iss_type;
  logic [3:0]  iss_funct;
  logic [31:0] iss_vj, iss_vk, iss_imm, iss_pc;
  logic [2:0]  iss_qj, iss_qk, iss_rob_id;
  logic        iss_rj, iss_rk;
  logic        alu_ready, lsb_ready;
  logic [2:0]  alu_rob_id, lsb_rob_id;
  logic [31:0] alu_value, lsb_value;
  logic        rs_full, ex_valid;
  logic [6:0]  ex_type;
  logic [3:0]  ex_funct;
  logic [31:0] ex_a, ex_b, ex_imm, ex_pc;
  logic [2:0]  ex_rob_id;

  reservation_station #(.RS_SIZE(8), .ROB_W(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .iss_valid(iss_valid), .iss_type(iss_type), .iss_funct(iss_funct),
    .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_qj(iss_qj), .iss_qk(iss_qk),
    .iss_rj(iss_rj), .iss_rk(iss_rk), .iss_rob_id(iss_rob_id),
    .iss_imm(iss_imm), .iss_pc(iss_pc),
    .alu_ready(alu_ready), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .rs_full(rs_full), .ex_valid(ex_valid), .ex_type(ex_type),
    .ex_funct(ex_funct), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .ex_rob_id(ex_rob_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  t;
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [2:0]  rob;
  } disp_t;

  disp_t exp_q[$];
  int checks    = 0;
  int failures  = 0;
  int disp_cnt  = 0;
  int d0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic disp_t mk(input logic [6:0] t, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] rob);
    return {t, {1'b0, rob}, a, b, 32'h100 + 32'(rob), 32'h1000 + 32'({rob, 2'b00}), rob};
  endfunction

  task automatic set_issue(input logic [6:0] t, input logic [31:0] vj, input logic [31:0] vk,
                           input logic [2:0] qj, input logic [2:0] qk,
                           input logic rj, input logic rk, input logic [2:0] rob);
    iss_valid  = 1'b1;
    iss_type   = t;
    iss_funct  = {1'b0, rob};
    iss_vj     = vj;
    iss_vk     = vk;
    iss_qj     = qj;
    iss_qk     = qk;
    iss_rj     = rj;
    iss_rk     = rk;
    iss_rob_id = rob;
    iss_imm    = 32'h100 + 32'(rob);
    iss_pc     = 32'h1000 + 32'({rob, 2'b00});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every dispatch must match the oldest outstanding expectation.
  always @(negedge clk) begin
    disp_t got, want;
    if (!rst && ex_valid) begin
      disp_cnt++;
      got = {ex_type, ex_funct, ex_a, ex_b, ex_imm, ex_pc, ex_rob_id};
      check("dispatch_pending", 160'(exp_q.size() != 0), 160'(1'b1));
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check("dispatch_payload", 160'(got), 160'(want));
      end
    end
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; iss_valid = 1'b0;
    iss_type = '0; iss_funct = '0; iss_vj = '0; iss_vk = '0; iss_qj = '0; iss_qk = '0;
    iss_rj = 1'b0; iss_rk = 1'b0; iss_rob_id = '0; iss_imm = '0; iss_pc = '0;
    alu_ready = 1'b0; alu_rob_id = '0; alu_value = '0;
    lsb_ready = 1'b0; lsb_rob_id = '0; lsb_value = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ex_valid", 160'(ex_valid), 160'(1'b0));
    check("rst_rs_full", 160'(rs_full), 160'(1'b0));
    check("rst_ex_fields", 160'({ex_type, ex_funct, ex_a, ex_b, ex_imm, ex_pc, ex_rob_id}), 160'(0));

    // Both operands ready at issue: dispatch on the 2nd edge.
    set_issue(C_R_TYPE, 32'd5, 32'd7, 3'd0, 3'd0, 1'b1, 1'b1, 3'd2);
    exp_q.push_back(mk(C_R_TYPE, 32'd5, 32'd7, 3'd2));
    tick();
    iss_valid = 1'b0;
    check("t1_edge1_valid", 160'(ex_valid), 160'(1'b0));
    check("t1_rs_full", 160'(rs_full), 160'(1'b0));
    tick();
    check("t1_edge2_valid", 160'(ex_valid), 160'(1'b1));
    check("t1_ex_a", 160'(ex_a), 160'(32'd5));
    check("t1_ex_b", 160'(ex_b), 160'(32'd7));
    check("t1_ex_rob", 160'(ex_rob_id), 160'(3'd2));
    tick();
    check("t1_pulse_end", 160'(ex_valid), 160'(1'b0));

    // Wakeup from the ALU bus.
    set_issue(C_I_TYPE, 32'd0, 32'd1, 3'd3, 3'd0, 1'b0, 1'b1, 3'd5);
    tick();
    iss_valid = 1'b0;
    tick(); tick();
    d0 = disp_cnt;
    alu_ready = 1'b1; alu_rob_id = 3'd3; alu_value = 32'h10;
    exp_q.push_back(mk(C_I_TYPE, 32'h10, 32'd1, 3'd5));
    tick();
    alu_ready = 1'b0;
    check("t2_latch_edge_valid", 160'(ex_valid), 160'(1'b0));
    tick();
    check("t2_disp_valid", 160'(ex_valid), 160'(1'b1));
    check("t2_ex_a", 160'(ex_a), 160'(32'h10));
    tick(); tick();
    check("t2_one_pulse", 160'(disp_cnt - d0), 160'(1));

    // Clear with a same-cycle issue: waiting entries and the new one vanish.
    for (int i = 0; i < 4; i++) begin
      set_issue(C_R_TYPE, 32'd0, 32'(i), 3'd6, 3'd0, 1'b0, 1'b1, 3'(i));
      tick();
    end
    set_issue(C_R_TYPE, 32'hAA, 32'hAB, 3'd0, 3'd0, 1'b1, 1'b1, 3'd7);
    clear = 1'b1;
    tick();
    clear = 1'b0; iss_valid = 1'b0;
    check("clr_ex_valid", 160'(ex_valid), 160'(1'b0));
    check("clr_rs_full", 160'(rs_full), 160'(1'b0));
    d0 = disp_cnt;
    alu_ready = 1'b1; alu_rob_id = 3'd6; alu_value = 32'h55;
    tick();
    alu_ready = 1'b0;
    tick(); tick(); tick();
    check("clr_no_dispatch", 160'(disp_cnt - d0), 160'(0));

    // Fill all slots waiting on tag 1, then release them together.
    for (int i = 0; i < 8; i++) begin
      set_issue(C_B_TYPE, 32'd0, 32'h200 + 32'(i), 3'd1, 3'd0, 1'b0, 1'b1, 3'(i));
      tick();
    end
    iss_valid = 1'b0;
    check("fill_rs_full", 160'(rs_full), 160'(1'b1));
    set_issue(C_AUIPC, 32'hBAD, 32'hBAD, 3'd0, 3'd0, 1'b1, 1'b1, 3'd7);
    tick();
    iss_valid = 1'b0;
    check("fill_9th_full", 160'(rs_full), 160'(1'b1));
    tick();
    check("fill_9th_ignored", 160'(ex_valid), 160'(1'b0));
    lsb_ready = 1'b1; lsb_rob_id = 3'd1; lsb_value = 32'h3C;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(C_B_TYPE, 32'h3C, 32'h200 + 32'(i), 3'(i)));
    tick();
    lsb_ready = 1'b0;
    check("fill_full_before_disp", 160'(rs_full), 160'(1'b1));
    for (int i = 0; i < 8; i++) begin
      tick();
      check("fill_disp_valid", 160'(ex_valid), 160'(1'b1));
      if (i == 0) check("fill_full_drops", 160'(rs_full), 160'(1'b0));
    end
    tick();
    check("fill_done_valid", 160'(ex_valid), 160'(1'b0));
    check("fill_queue_empty", 160'(exp_q.size()), 160'(0));

    // Result broadcast in the issue cycle.
    set_issue(C_JALR, 32'h60, 32'd0, 3'd0, 3'd4, 1'b1, 1'b0, 3'd4);
    alu_ready = 1'b1; alu_rob_id = 3'd4; alu_value = 32'd9;
`ifdef RS_BYPASS_EN
    exp_q.push_back(mk(C_JALR, 32'h60, 32'd9, 3'd4));
`endif
    tick();
    iss_valid = 1'b0; alu_ready = 1'b0;
    tick();
`ifdef RS_BYPASS_EN
    check("byp_valid", 160'(ex_valid), 160'(1'b1));
    check("byp_ex_b", 160'(ex_b), 160'(32'd9));
    tick();
`else
    check("nobyp_waiting", 160'(ex_valid), 160'(1'b0));
    d0 = disp_cnt;
    tick(); tick();
    check("nobyp_still_waiting", 160'(disp_cnt - d0), 160'(0));
    lsb_ready = 1'b1; lsb_rob_id = 3'd4; lsb_value = 32'h33;
    exp_q.push_back(mk(C_JALR, 32'h60, 32'h33, 3'd4));
    tick();
    lsb_ready = 1'b0;
    tick();
    check("nobyp_late_valid", 160'(ex_valid), 160'(1'b1));
    check("nobyp_late_ex_b", 160'(ex_b), 160'(32'h33));
    tick();
`endif

    // rdy low freezes issue, wakeup and dispatch.
    set_issue(C_R_TYPE, 32'd0, 32'h41, 3'd2, 3'd0, 1'b0, 1'b1, 3'd1);
    tick();
    set_issue(C_R_TYPE, 32'h51, 32'h52, 3'd0, 3'd0, 1'b1, 1'b1, 3'd2);
    tick();
    set_issue(C_R_TYPE, 32'hE0, 32'hE1, 3'd0, 3'd0, 1'b1, 1'b1, 3'd6);
    rdy = 1'b0;
    alu_ready = 1'b1; alu_rob_id = 3'd2; alu_value = 32'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdy_low_no_disp", 160'(ex_valid), 160'(1'b0));
    end
    iss_valid = 1'b0; alu_ready = 1'b0; rdy = 1'b1;
    exp_q.push_back(mk(C_R_TYPE, 32'h51, 32'h52, 3'd2));
    tick();
    check("rdy_resume_valid", 160'(ex_valid), 160'(1'b1));
    check("rdy_resume_rob", 160'(ex_rob_id), 160'(3'd2));
    tick();
    check("rdy_no_wakeup", 160'(ex_valid), 160'(1'b0));
    alu_ready = 1'b1; alu_rob_id = 3'd2; alu_value = 32'h77;
    exp_q.push_back(mk(C_R_TYPE, 32'h77, 32'h41, 3'd1));
    tick();
    alu_ready = 1'b0;
    tick();
    check("rdy_late_valid", 160'(ex_valid), 160'(1'b1));
    check("rdy_late_ex_a", 160'(ex_a), 160'(32'h77));

    tick(); tick(); tick();
    check("queue_drained", 160'(exp_q.size()), 160'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
